// File: rtl/mem_port_if.sv
// Bundle of core-side fetch/data buses and memory-macro signals around the port arbiter.
// The master side is the core plus memory macro; the slave side is the arbiter.
interface mem_port_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_kill;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;
    logic              stall_if;
    logic              stall_dm;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output if_req, if_addr, if_kill, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready, stall_if, stall_dm,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, if_kill, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready, stall_if, stall_dm,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch and data ports,
// sequencing grant / issue / latency wait / completion and producing stage stalls.
//
// Handshake: a requester raises *_req with address/data valid and holds it until
// *_ready pulses for one cycle; the arbiter latches the request at grant, so the
// requester may change address/data afterwards without effect on the transaction.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    mem_port_if.slave  bus,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        lat_cnt;
    logic [3:0]        starve_cnt;
    logic              kill_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              grant_i;
    logic              grant_d;
    logic              done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Data wins a tie unless fetch has been passed over STARVE_LIMIT times in a row.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        done      = (lat_cnt == 4'd0);
        case (state)
            IDLE: begin
                if (bus.if_req && bus.dm_req) begin
                    if (starve_cnt == 4'(STARVE_LIMIT)) begin
                        grant_i = 1'b1;
                    end else begin
                        grant_d = 1'b1;
                    end
                end else if (bus.dm_req) begin
                    grant_d = 1'b1;
                end else if (bus.if_req) begin
                    grant_i = 1'b1;
                end
                if (grant_i) begin
                    state_nxt = BUSY_I;
                end else if (grant_d) begin
                    state_nxt = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.if_ready = (state == BUSY_I) && done && !kill_q;
        bus.dm_ready = (state == BUSY_D) && done;
        bus.if_rdata = bus.if_ready ? bus.mem_rdata : if_rdata_q;
        bus.dm_rdata = bus.dm_ready ? bus.mem_rdata : dm_rdata_q;
        bus.stall_if = bus.if_req & ~bus.if_ready;
        bus.stall_dm = bus.dm_req & ~bus.dm_ready;
        dbg_state    = state;
    end

    // Transaction registers: latched at grant, held until completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= {ADDR_W{1'b0}};
            bus.mem_wdata <= {DATA_W{1'b0}};
            lat_cnt       <= 4'd0;
        end else begin
            bus.mem_en <= grant_i | grant_d;
            if (grant_d) begin
                bus.mem_addr  <= bus.dm_addr;
                bus.mem_we    <= bus.dm_we;
                bus.mem_wdata <= bus.dm_wdata;
                lat_cnt       <= 4'(MEM_LATENCY);
            end else if (grant_i) begin
                bus.mem_addr <= bus.if_addr;
                bus.mem_we   <= 1'b0;
                lat_cnt      <= 4'(MEM_LATENCY);
            end else if (state != IDLE) begin
                if (done) begin
                    bus.mem_we <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= 4'd0;
            kill_q     <= 1'b0;
            if_rdata_q <= {DATA_W{1'b0}};
            dm_rdata_q <= {DATA_W{1'b0}};
        end else begin
            if (grant_i) begin
                starve_cnt <= 4'd0;
            end else if (grant_d && bus.if_req) begin
                if (starve_cnt != 4'hF) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else if ((state == IDLE) && !bus.if_req) begin
                starve_cnt <= 4'd0;
            end

            // A redirect drops only the response; the memory access still runs out.
            if ((state == BUSY_I) && done) begin
                kill_q <= 1'b0;
            end else if ((state == BUSY_I) && bus.if_kill) begin
                kill_q <= 1'b1;
            end

            if (bus.if_ready) begin
                if_rdata_q <= bus.mem_rdata;
            end
            if (bus.dm_ready) begin
                dm_rdata_q <= bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level reference model predicts
// issue strobes and completions into queues that a negedge monitor pops and compares.
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LAT        = 2;
    localparam int LIMIT      = 4;
    localparam int RUN_CYCLES = 3000;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } iss_t;

    typedef struct {
        int          cyc;
        logic        chk_data;
        logic [31:0] data;
    } rsp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;
    int         cyc = 0;
    int         checks = 0;
    int         passes = 0;

    mem_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle index ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- scoreboard queues ----------------
    iss_t iss_q[$];
    rsp_t if_q[$];
    rsp_t dm_q[$];

    // ---------------- memory macro stub ----------------
    logic [31:0] resp[int];
    always @(negedge clk) if (bus.mem_en === 1'b1) resp[cyc + LAT] = mem_fn(bus.mem_addr);
    always @(posedge clk) begin
        #1;
        if (resp.exists(cyc)) begin
            bus.mem_rdata = resp[cyc];
            resp.delete(cyc);
        end else begin
            bus.mem_rdata = $urandom;
        end
    end

    // ---------------- reference model (one step per cycle) ----------------
    bit m_busy = 0;
    bit m_fetch = 0;
    bit m_killed = 0;
    int m_done = 0;
    int m_starve = 0;

    always @(posedge clk) begin
        bit   gi, gd;
        iss_t it;
        rsp_t rt;
        gi = 0;
        gd = 0;
        if (reset) begin
            m_busy = 0;
            m_starve = 0;
            iss_q.delete();
            if_q.delete();
            dm_q.delete();
        end else if (m_busy) begin
            if (m_fetch && bus.if_kill && cyc < m_done && !m_killed) begin
                m_killed = 1;
                if (if_q.size() > 0) void'(if_q.pop_back());
            end
            if (cyc == m_done) m_busy = 0;
        end else begin
            if (bus.if_req && bus.dm_req) begin
                if (m_starve == LIMIT) gi = 1;
                else gd = 1;
            end else begin
                gi = bus.if_req;
                gd = bus.dm_req;
            end
            if (gd) begin
                m_starve = bus.if_req ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
                it.cyc = cyc + 1; it.addr = bus.dm_addr; it.we = bus.dm_we; it.wdata = bus.dm_wdata;
                iss_q.push_back(it);
                rt.cyc = cyc + 1 + LAT; rt.chk_data = !bus.dm_we; rt.data = mem_fn(bus.dm_addr);
                dm_q.push_back(rt);
            end else if (gi) begin
                m_starve = 0;
                it.cyc = cyc + 1; it.addr = bus.if_addr; it.we = 1'b0; it.wdata = '0;
                iss_q.push_back(it);
                rt.cyc = cyc + 1 + LAT; rt.chk_data = 1'b1; rt.data = mem_fn(bus.if_addr);
                if_q.push_back(rt);
            end else if (!bus.if_req) begin
                m_starve = 0;
            end
            if (gd || gi) begin
                m_busy = 1;
                m_fetch = gi;
                m_killed = 0;
                m_done = cyc + 1 + LAT;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [31:0] if_hold = '0;
    logic [31:0] dm_hold = '0;
    bit          dm_known = 1;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;
    int          hold_end = -1;

    always @(negedge clk) begin
        logic exp_en, exp_if, exp_dm;
        iss_t it;
        rsp_t rt;
        if (cyc >= 1) begin
            exp_en = (iss_q.size() > 0) && (iss_q[0].cyc == cyc);
            chk("mem_en", 64'(bus.mem_en), 64'(exp_en));
            if (exp_en) begin
                it = iss_q.pop_front();
                h_addr = it.addr; h_we = it.we; h_wdata = it.wdata;
                hold_end = cyc + LAT;
            end
            if (cyc <= hold_end) begin
                chk("mem_addr", 64'(bus.mem_addr), 64'(h_addr));
                chk("mem_we", 64'(bus.mem_we), 64'(h_we));
                if (h_we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(h_wdata));
            end

            exp_if = (if_q.size() > 0) && (if_q[0].cyc == cyc);
            chk("if_ready", 64'(bus.if_ready), 64'(exp_if));
            if (exp_if) begin
                rt = if_q.pop_front();
                chk("if_rdata", 64'(bus.if_rdata), 64'(rt.data));
                if_hold = rt.data;
            end else begin
                chk("if_rdata_hold", 64'(bus.if_rdata), 64'(if_hold));
            end

            exp_dm = (dm_q.size() > 0) && (dm_q[0].cyc == cyc);
            chk("dm_ready", 64'(bus.dm_ready), 64'(exp_dm));
            if (exp_dm) begin
                rt = dm_q.pop_front();
                if (rt.chk_data) begin
                    chk("dm_rdata", 64'(bus.dm_rdata), 64'(rt.data));
                    dm_hold = rt.data;
                end
                dm_known = rt.chk_data;
            end else if (dm_known) begin
                chk("dm_rdata_hold", 64'(bus.dm_rdata), 64'(dm_hold));
            end

            chk("stall_if", 64'(bus.stall_if), 64'(bus.if_req & ~exp_if));
            chk("stall_dm", 64'(bus.stall_dm), 64'(bus.dm_req & ~exp_dm));

            if (reset) begin
                if_hold = '0;
                dm_hold = '0;
                dm_known = 1;
                hold_end = -1;
            end
        end
    end

    // ---------------- requester-side completion observation ----------------
    bit if_seen = 0;
    bit dm_seen = 0;
    always @(negedge clk) begin
        if (bus.if_ready === 1'b1) if_seen = 1;
        if (bus.dm_ready === 1'b1) dm_seen = 1;
    end

    // ---------------- reset-state checks ----------------
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
    end

    // ---------------- driver ----------------
    initial begin
        bit stim;
        reset = 1'b1;
        bus.if_req = 0; bus.if_addr = '0; bus.if_kill = 0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.mem_rdata = '0;
        for (int k = 0; k < RUN_CYCLES + 60; k++) begin
            @(posedge clk);
            #1;
            stim = (k < RUN_CYCLES);
            reset = (k < 3) || (stim && $urandom_range(0, 299) == 0);
            bus.if_kill = 1'b0;

            if (if_seen) begin
                if_seen = 0;
                bus.if_req = 1'b0;
            end
            if (!bus.if_req) begin
                if (stim && $urandom_range(0, 1) == 0) begin
                    bus.if_req = 1'b1;
                    bus.if_addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                end
            end else if (stim && $urandom_range(0, 9) == 0) begin
                bus.if_kill = 1'b1;
                bus.if_addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            end

            if (dm_seen) begin
                dm_seen = 0;
                bus.dm_req = 1'b0;
            end
            if (!bus.dm_req && stim && $urandom_range(0, 1) == 0) begin
                bus.dm_req = 1'b1;
                bus.dm_we = $urandom_range(0, 1);
                bus.dm_addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                bus.dm_wdata = $urandom;
            end
        end
        @(negedge clk);
        chk("drain_issue_q", 64'(iss_q.size()), 64'd0);
        chk("drain_if_q", 64'(if_q.size()), 64'd0);
        chk("drain_dm_q", 64'(dm_q.size()), 64'd0);
        chk("drain_if_req", 64'(bus.if_req), 64'd0);
        chk("drain_dm_req", 64'(bus.dm_req), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the pipelined core's fetch port and data port.
- Sequences every access: grant, issue, wait for latency, complete.
- Generates stall signals so the hazard logic freezes the F or M stage until its access completes.
- Sits between the core datapath (instruction/data buses) and the memory macro.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LATENCY, 2, cycles from the mem_en cycle to the mem_rdata-valid cycle; legal range 1..15.
- STARVE_LIMIT, 4, consecutive data grants with fetch waiting before fetch is forced; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous active-high reset
- if_req  input  1  fetch request; held until if_ready
- if_addr  input  ADDR_W  fetch address
- if_kill  input  1  fetch redirect; drops the in-flight fetch response
- if_rdata  output  DATA_W  fetched instruction
- if_ready  output  1  one-cycle completion pulse for fetch
- dm_req  input  1  data request; held until dm_ready
- dm_we  input  1  data write enable
- dm_addr  input  ADDR_W  data address
- dm_wdata  input  DATA_W  store data
- dm_rdata  output  DATA_W  load data
- dm_ready  output  1  one-cycle completion pulse for data
- stall_if  output  1  if_req & ~if_ready
- stall_dm  output  1  dm_req & ~dm_ready
- mem_en  output  1  one-cycle issue strobe
- mem_we  output  1  write enable, held for the whole transaction
- mem_addr  output  ADDR_W  held for the whole transaction
- mem_wdata  output  DATA_W  held for the whole transaction
- mem_rdata  input  DATA_W  valid exactly MEM_LATENCY cycles after mem_en

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE grant rule:
  - Neither request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant data unless starve_cnt == STARVE_LIMIT, then grant fetch.
- Grant at cycle t: mem_addr, mem_we, mem_wdata are registered at the t edge. mem_en=1 in cycle t+1 only. Fetch grants always drive mem_we=0.
- Latency counter loads MEM_LATENCY on issue and decrements each cycle.
- Completion occurs in cycle t+1+MEM_LATENCY:
  - The matching *_ready pulses for one cycle.
  - *_rdata = mem_rdata (combinational pass-through).
  - FSM returns to IDLE next cycle.
  - Bus occupancy per access is MEM_LATENCY+2 cycles; a fresh grant is possible in the cycle after ready.
- Writes complete identically. dm_rdata is don't-care on writes.
- When no completion is active, *_rdata hold their last value; their reset value is 0.
- starve_cnt (4-bit):
  - Increments, saturating, on each data grant made while if_req=1.
  - Clears on a fetch grant.
  - Clears when if_req=0 in IDLE.
- if_kill:
  - Sampled in any BUSY_I cycle.
  - Sets a kill flag that suppresses if_ready at completion; the memory access still finishes its latency before IDLE.
  - if_kill in IDLE, or while BUSY_D, has no effect.
  - stall_if stays 1 while if_req=1 and no unsuppressed if_ready has occurred.
- If a requester drops its req mid-transaction: the transaction completes and ready still pulses; the requester ignores it.
- Address or data changes during BUSY are ignored because values are latched at grant.
- Reset (any cycle, including mid-transaction) forces:
  - FSM to IDLE; mem_en, mem_we, if_ready, dm_ready to 0.
  - mem_addr, mem_wdata, rdata registers, starve_cnt, latency counter, kill flag to 0.
  - Any outstanding memory response is discarded.
  - Grants may occur in the first cycle after reset deasserts.
- stall_if and stall_dm are purely combinational from req/ready, so they are 0 during reset unless req=1.

Test Plan:
All scenarios use MEM_LATENCY=2, STARVE_LIMIT=4.
1. if_req=1, if_addr=0x100 in cycle 0 (IDLE), mem_rdata=0x00500093 in cycle 3 -> mem_en=1 and mem_addr=0x100 in cycle 1; if_ready=1 and if_rdata=0x00500093 in cycle 3; stall_if=1 in cycles 0-2.
2. if_req and dm_req (load, dm_addr=0x200) both asserted in cycle 0 -> data issued in cycle 1, dm_ready in cycle 3; fetch granted in cycle 4, mem_en in cycle 5, if_ready in cycle 7.
3. Store with dm_we=1, dm_addr=0x204, dm_wdata=0xDEADBEEF -> cycles 1-3 mem_we=1, mem_addr=0x204, mem_wdata=0xDEADBEEF; dm_ready in cycle 3; mem_en high only in cycle 1.
4. dm_req and if_req held continuously -> grants go D,D,D,D then I (fifth grant is fetch, mem_en cycle 17), then D again; starve_cnt returns to 0.
5. Fetch issued in cycle 1 with if_kill=1 in cycle 2 -> no if_ready in cycle 3; FSM in IDLE in cycle 4; a new if_req grant issues mem_en in cycle 5.
6. Load in flight with reset=1 in cycle 2 -> cycle 3 shows mem_en=0, dm_ready=0, all outputs at reset values; dm_req held after reset deasserts -> new mem_en one cycle later, normal completion.
